// File: rtl/root_host_bridge_if.sv
// Bundle of the host command/response, interrupt and root-node request signals.
// The bridge takes the slave view; the host plus root-node environment takes the master view.
interface root_host_bridge_if #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 16,
   parameter int RDATA_WIDTH = 16
);
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic                   cmd_write;
   logic [ADDR_WIDTH-1:0]  cmd_addr;
   logic [DATA_WIDTH-1:0]  cmd_data;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [RDATA_WIDTH-1:0] rsp_data;
   logic                   irq_pending;
   logic                   irq_clear;
   logic                   write_en;
   logic [ADDR_WIDTH-1:0]  write_addr;
   logic [DATA_WIDTH-1:0]  write_data;
   logic                   write_rdy;
   logic                   read_en;
   logic [ADDR_WIDTH-1:0]  read_addr;
   logic                   read_rdy;
   logic                   read_data_vld;
   logic                   read_data_rdy;
   logic [RDATA_WIDTH-1:0] read_data;
   logic                   interrupt;

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_data, rsp_ready, irq_clear,
             write_rdy, read_rdy, read_data_vld, read_data, interrupt,
      output cmd_ready, rsp_valid, rsp_data, irq_pending, write_en, write_addr,
             write_data, read_en, read_addr, read_data_rdy
   );

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_data, rsp_ready, irq_clear,
             write_rdy, read_rdy, read_data_vld, read_data, interrupt,
      input  cmd_ready, rsp_valid, rsp_data, irq_pending, write_en, write_addr,
             write_data, read_en, read_addr, read_data_rdy
   );
endinterface

// File: rtl/root_host_bridge.sv
// Host front end for the root node: in-order command FIFO feeding write/read requests,
// credit-protected response FIFO for returned read data, and a sticky interrupt latch.
module root_host_bridge #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 16,
   parameter int RDATA_WIDTH = 16,
   parameter int CMD_DEPTH   = 4,
   parameter int RSP_DEPTH   = 4
) (
   input logic               clk,
   input logic               rst_n,
   root_host_bridge_if.slave bus
);
   localparam int CAW   = $clog2(CMD_DEPTH);
   localparam int RAW   = $clog2(RSP_DEPTH);
   localparam int CMD_W = 1 + ADDR_WIDTH + DATA_WIDTH;
   localparam logic [RAW+1:0] RSP_LIMIT = (RAW+2)'(RSP_DEPTH);

   logic [CMD_W-1:0]       cmd_mem_q [CMD_DEPTH];
   logic [CAW:0]           cmd_wptr_q, cmd_rptr_q;
   logic [RDATA_WIDTH-1:0] rsp_mem_q [RSP_DEPTH];
   logic [RAW:0]           rsp_wptr_q, rsp_rptr_q;
   logic [RAW:0]           outstanding_q, outstanding_d;
   logic                   irq_q, irq_d;

   logic                   cmd_empty_s, cmd_full_s, rsp_empty_s, rsp_full_s;
   logic [CMD_W-1:0]       head_s;
   logic                   head_write_s;
   logic [RAW:0]           rsp_count_s;
   logic [RAW+1:0]         credit_sum_s;
   logic                   credit_ok_s;
   logic                   write_en_s, read_en_s;
   logic                   cmd_push_s, cmd_pop_s, rd_accept_s, rsp_push_s, rsp_pop_s;

   // Extra pointer MSB separates full from empty when the index bits match.
   assign cmd_empty_s  = (cmd_wptr_q == cmd_rptr_q);
   assign cmd_full_s   = (cmd_wptr_q[CAW] != cmd_rptr_q[CAW]) &&
                         (cmd_wptr_q[CAW-1:0] == cmd_rptr_q[CAW-1:0]);
   assign rsp_empty_s  = (rsp_wptr_q == rsp_rptr_q);
   assign rsp_full_s   = (rsp_wptr_q[RAW] != rsp_rptr_q[RAW]) &&
                         (rsp_wptr_q[RAW-1:0] == rsp_rptr_q[RAW-1:0]);

   assign head_s       = cmd_mem_q[cmd_rptr_q[CAW-1:0]];
   assign head_write_s = head_s[CMD_W-1];
   assign rsp_count_s  = rsp_wptr_q - rsp_rptr_q;
   assign credit_sum_s = {1'b0, outstanding_q} + {1'b0, rsp_count_s};
   assign credit_ok_s  = (credit_sum_s < RSP_LIMIT);

   // Head dispatch decode and next-state for credit counter and interrupt latch.
   always_comb begin
      write_en_s    = 1'b0;
      read_en_s     = 1'b0;
      outstanding_d = outstanding_q;
      irq_d         = irq_q;
      if (!cmd_empty_s) begin
         if (head_write_s) begin
            write_en_s = 1'b1;
         end else begin
            read_en_s = credit_ok_s;
         end
      end else begin
         write_en_s = 1'b0;
      end
      case ({rd_accept_s, rsp_push_s})
         2'b10:   outstanding_d = outstanding_q + (RAW+1)'(1);
         2'b01: begin
            if (outstanding_q != (RAW+1)'(0)) begin
               outstanding_d = outstanding_q - (RAW+1)'(1);
            end else begin
               outstanding_d = outstanding_q;
            end
         end
         default: outstanding_d = outstanding_q;
      endcase
      if (bus.interrupt) begin
         irq_d = 1'b1;
      end else if (bus.irq_clear) begin
         irq_d = 1'b0;
      end else begin
         irq_d = irq_q;
      end
   end

   assign rd_accept_s = read_en_s && bus.read_rdy;
   assign cmd_push_s  = bus.cmd_valid && !cmd_full_s;
   assign cmd_pop_s   = (write_en_s && bus.write_rdy) || rd_accept_s;
   assign rsp_push_s  = bus.read_data_vld && !rsp_full_s;
   assign rsp_pop_s   = !rsp_empty_s && bus.rsp_ready;

   assign bus.cmd_ready     = !cmd_full_s;
   assign bus.write_en      = write_en_s;
   assign bus.read_en       = read_en_s;
   assign bus.write_addr    = head_s[CMD_W-2 -: ADDR_WIDTH];
   assign bus.read_addr     = head_s[CMD_W-2 -: ADDR_WIDTH];
   assign bus.write_data    = head_s[DATA_WIDTH-1:0];
   assign bus.read_data_rdy = !rsp_full_s;
   assign bus.rsp_valid     = !rsp_empty_s;
   assign bus.rsp_data      = rsp_mem_q[rsp_rptr_q[RAW-1:0]];
   assign bus.irq_pending   = irq_q;

   // Pointers, credit counter and interrupt latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_wptr_q    <= '0;
         cmd_rptr_q    <= '0;
         rsp_wptr_q    <= '0;
         rsp_rptr_q    <= '0;
         outstanding_q <= '0;
         irq_q         <= 1'b0;
      end else begin
         if (cmd_push_s) cmd_wptr_q <= cmd_wptr_q + (CAW+1)'(1);
         if (cmd_pop_s)  cmd_rptr_q <= cmd_rptr_q + (CAW+1)'(1);
         if (rsp_push_s) rsp_wptr_q <= rsp_wptr_q + (RAW+1)'(1);
         if (rsp_pop_s)  rsp_rptr_q <= rsp_rptr_q + (RAW+1)'(1);
         outstanding_q <= outstanding_d;
         irq_q         <= irq_d;
      end
   end

   // FIFO storage, cleared on reset so the head outputs never show stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CMD_DEPTH; i++) cmd_mem_q[i] <= '0;
         for (int j = 0; j < RSP_DEPTH; j++) rsp_mem_q[j] <= '0;
      end else begin
         if (cmd_push_s) begin
            cmd_mem_q[cmd_wptr_q[CAW-1:0]] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_data};
         end
         if (rsp_push_s) begin
            rsp_mem_q[rsp_wptr_q[RAW-1:0]] <= bus.read_data;
         end
      end
   end
endmodule

// File: tb/tb_root_host_bridge.sv
// Directed self-checking bench for root_host_bridge with hand-computed expectations.
module tb_root_host_bridge;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;
   int   rd_hs = 0;
   int   wr_hs = 0;
   logic [15:0] exp_rsp [4];

   always #5 clk = ~clk;

   root_host_bridge_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .RDATA_WIDTH(16)) bus ();

   root_host_bridge #(
      .ADDR_WIDTH(16), .DATA_WIDTH(16), .RDATA_WIDTH(16), .CMD_DEPTH(4), .RSP_DEPTH(4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Handshakes are counted from the values present just before the rising edge.
   task automatic tick();
      if (bus.read_en && bus.read_rdy) rd_hs++;
      if (bus.write_en && bus.write_rdy) wr_hs++;
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic w, input logic [15:0] a, input logic [15:0] d);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_data  = d;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic return_data(input logic [15:0] d);
      bus.read_data_vld = 1'b1;
      bus.read_data     = d;
      tick();
      bus.read_data_vld = 1'b0;
   endtask

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 16'h0; bus.cmd_data = 16'h0;
      bus.rsp_ready = 1'b0; bus.irq_clear = 1'b0; bus.write_rdy = 1'b0; bus.read_rdy = 1'b0;
      bus.read_data_vld = 1'b0; bus.read_data = 16'h0; bus.interrupt = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_write_en", 32'(bus.write_en), 32'd0);
      chk("rst_read_en", 32'(bus.read_en), 32'd0);
      chk("rst_read_data_rdy", 32'(bus.read_data_rdy), 32'd1);
      chk("rst_irq", 32'(bus.irq_pending), 32'd0);
      rst_n = 1'b1;
      tick();

      // Write stream
      bus.write_rdy = 1'b1;
      push_cmd(1'b1, 16'h0010, 16'hAAAA);
      chk("ws_en0", 32'(bus.write_en), 32'd1);
      chk("ws_wd0", {bus.write_addr, bus.write_data}, 32'h0010_AAAA);
      push_cmd(1'b1, 16'h0011, 16'hBBBB);
      chk("ws_wd1", {bus.write_addr, bus.write_data}, 32'h0011_BBBB);
      push_cmd(1'b1, 16'h0012, 16'hCCCC);
      chk("ws_wd2", {bus.write_addr, bus.write_data}, 32'h0012_CCCC);
      chk("ws_rd_off", 32'(bus.read_en), 32'd0);
      tick();
      chk("ws_empty_en", 32'(bus.write_en), 32'd0);
      chk("ws_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("ws_count", 32'(wr_hs), 32'd3);

      // Backpressure
      bus.write_rdy = 1'b0;
      push_cmd(1'b1, 16'h0010, 16'h1000);
      chk("bp_ready1", 32'(bus.cmd_ready), 32'd1);
      push_cmd(1'b1, 16'h0011, 16'h1001);
      push_cmd(1'b1, 16'h0012, 16'h1002);
      push_cmd(1'b1, 16'h0013, 16'h1003);
      chk("bp_full", 32'(bus.cmd_ready), 32'd0);
      tick();
      chk("bp_hold_addr", 32'(bus.write_addr), 32'h0010);
      chk("bp_hold_en", 32'(bus.write_en), 32'd1);
      bus.write_rdy = 1'b1;
      chk("bp_no_bypass", 32'(bus.cmd_ready), 32'd0);
      tick();
      chk("bp_ready_after_pop", 32'(bus.cmd_ready), 32'd1);
      chk("bp_next_addr", 32'(bus.write_addr), 32'h0011);
      tick();
      chk("bp_addr2", 32'(bus.write_addr), 32'h0012);
      tick();
      chk("bp_addr3", 32'(bus.write_addr), 32'h0013);
      tick();
      chk("bp_drained", 32'(bus.write_en), 32'd0);

      // Credit stall: six reads, four credits
      rd_hs = 0;
      bus.read_rdy = 1'b1;
      for (int i = 0; i < 6; i++) push_cmd(1'b0, 16'h0020 + 16'(i), 16'h0);
      chk("cr_stall_en", 32'(bus.read_en), 32'd0);
      chk("cr_hs4", 32'(rd_hs), 32'd4);
      chk("cr_head_addr", 32'(bus.read_addr), 32'h0024);
      tick(); tick();
      chk("cr_still_stalled", 32'(rd_hs), 32'd4);
      return_data(16'hD000);
      chk("cr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("cr_stall_rsp1", 32'(bus.read_en), 32'd0);
      return_data(16'hD001);
      return_data(16'hD002);
      return_data(16'hD003);
      chk("cr_rsp_full", 32'(bus.read_data_rdy), 32'd0);
      chk("cr_rsp_head", 32'(bus.rsp_data), 32'hD000);
      chk("cr_stall_full", 32'(bus.read_en), 32'd0);
      bus.rsp_ready = 1'b1;
      tick();
      chk("cr_resume_en", 32'(bus.read_en), 32'd1);
      chk("cr_resume_addr", 32'(bus.read_addr), 32'h0024);
      chk("cr_rsp_head1", 32'(bus.rsp_data), 32'hD001);
      tick();
      bus.rsp_ready = 1'b0;
      chk("cr_addr5", 32'(bus.read_addr), 32'h0025);
      tick();
      chk("cr_hs6", 32'(rd_hs), 32'd6);
      chk("cr_idle", 32'(bus.read_en), 32'd0);
      return_data(16'hD004);
      return_data(16'hD005);
      exp_rsp[0] = 16'hD002; exp_rsp[1] = 16'hD003; exp_rsp[2] = 16'hD004; exp_rsp[3] = 16'hD005;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("cr_rsp_order%0d", i), 32'(bus.rsp_data), 32'(exp_rsp[i]));
         tick();
      end
      bus.rsp_ready = 1'b0;
      chk("cr_rsp_empty", 32'(bus.rsp_valid), 32'd0);

      // Ordering: read A, write B, read C with the read port stalled
      bus.read_rdy = 1'b0;
      wr_hs = 0;
      push_cmd(1'b0, 16'h0030, 16'h0);
      push_cmd(1'b1, 16'h0031, 16'hB0B0);
      push_cmd(1'b0, 16'h0032, 16'h0);
      chk("or_no_write", 32'(bus.write_en), 32'd0);
      chk("or_head_a", 32'(bus.read_addr), 32'h0030);
      chk("or_wr_count0", 32'(wr_hs), 32'd0);
      bus.read_rdy = 1'b1;
      tick();
      chk("or_write_b", {15'd0, bus.write_en, bus.write_addr}, 32'h0001_0031);
      chk("or_excl", 32'(bus.read_en), 32'd0);
      tick();
      chk("or_read_c", {15'd0, bus.read_en, bus.read_addr}, 32'h0001_0032);
      tick();
      chk("or_wr_count1", 32'(wr_hs), 32'd1);
      return_data(16'hA0A0);
      return_data(16'hC0C0);
      chk("or_rsp_a", 32'(bus.rsp_data), 32'hA0A0);
      bus.rsp_ready = 1'b1;
      tick();
      chk("or_rsp_c", 32'(bus.rsp_data), 32'hC0C0);
      tick();
      bus.rsp_ready = 1'b0;
      chk("or_rsp_empty", 32'(bus.rsp_valid), 32'd0);

      // Interrupt latch
      bus.interrupt = 1'b1;
      tick();
      bus.interrupt = 1'b0;
      chk("irq_set", 32'(bus.irq_pending), 32'd1);
      tick();
      chk("irq_held", 32'(bus.irq_pending), 32'd1);
      bus.interrupt = 1'b1; bus.irq_clear = 1'b1;
      tick();
      bus.interrupt = 1'b0;
      chk("irq_set_wins", 32'(bus.irq_pending), 32'd1);
      tick();
      bus.irq_clear = 1'b0;
      chk("irq_cleared", 32'(bus.irq_pending), 32'd0);

      // Reset mid-operation: one outstanding read, two queued writes
      bus.write_rdy = 1'b0;
      bus.read_rdy  = 1'b1;
      push_cmd(1'b0, 16'h0040, 16'h0);
      push_cmd(1'b1, 16'h0041, 16'h4141);
      push_cmd(1'b1, 16'h0042, 16'h4242);
      chk("mr_pre_write_en", 32'(bus.write_en), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_write_en", 32'(bus.write_en), 32'd0);
      chk("mr_read_en", 32'(bus.read_en), 32'd0);
      chk("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mr_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      tick();
      rst_n = 1'b1;
      tick();
      bus.write_rdy = 1'b1;
      push_cmd(1'b1, 16'h0050, 16'h5050);
      chk("mr_fresh_cmd", {bus.write_addr, bus.write_data}, 32'h0050_5050);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
